// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcodes, register sentinel, FSM states, decode helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package y86_pkg;

    localparam int N = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    // Instructions carrying a register specifier byte at offset 1.
    function automatic logic need_regids(input logic [3:0] icode);
        logic r;
        case (icode)
            I_CMOVXX, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions carrying an 8-byte little-endian constant.
    function automatic logic need_valC(input logic [3:0] icode);
        logic r;
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

    // Legal (icode, ifun) combinations; icodes above POPQ are never legal.
    function automatic logic ifun_legal(input logic [3:0] icode, input logic [3:0] ifun);
        logic r;
        case (icode)
            I_CMOVXX, I_JXX: r = (ifun <= 4'd6);
            I_OPQ:           r = (ifun <= 4'd3);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: r = (ifun == 4'd0);
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Instruction length decoder: icode -> register-byte flag, constant flag, byte length.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_need_regids,
    output logic       o_need_valc,
    output logic [3:0] o_len
);

    logic w_need_regids;
    logic w_need_valc;

    assign w_need_regids = need_regids(i_icode);
    assign w_need_valc   = need_valC(i_icode);

    // One opcode byte, plus an optional register byte, plus an optional 8-byte constant.
    // Illegal icodes decode as 1 byte so the fetch stops after byte 0.
    assign o_len         = 4'd1 + {3'd0, w_need_regids} + {w_need_valc, 3'b000};
    assign o_need_regids = w_need_regids;
    assign o_need_valc   = w_need_valc;

endmodule

// File: rtl/y86_fetch_unit.sv
// Byte-serial Y86-64 fetch: accepts a PC, reads one byte per memory ack, splits fields.
// Latency: out_valid len+1 cycles after PC acceptance with zero-wait memory; +1 per wait state.
// Backpressure: results held in DONE until out_ready; no new PC accepted until back in IDLE.
module y86_fetch_unit
    import y86_pkg::*;
(
    input  logic         clk,
    input  logic         async_reset_n,
    input  logic [N-1:0] pc_in,
    input  logic         pc_valid,
    output logic         pc_ready,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_err,
    output logic [3:0]   icode,
    output logic [3:0]   ifun,
    output logic [3:0]   rA,
    output logic [3:0]   rB,
    output logic [N-1:0] valC,
    output logic [N-1:0] valP,
    output logic         instr_valid,
    output logic         imem_error,
    output logic         out_valid,
    input  logic         out_ready
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [N-1:0] r_pc;
    logic [3:0]   r_idx;
    logic [3:0]   r_len;
    logic         r_need_regids;
    logic         r_need_valc;
    logic [3:0]   r_icode;
    logic [3:0]   r_ifun;
    logic [3:0]   r_ra;
    logic [3:0]   r_rb;
    logic [N-1:0] r_valc;
    logic [N-1:0] r_valp;
    logic         r_instr_valid;
    logic         r_imem_error;

    logic         w_pc_ready;
    logic         w_mem_req;
    logic         w_out_valid;
    logic         w_accept;
    logic         w_ack;
    logic         w_legal;
    logic         w_need_regids;
    logic         w_need_valc;
    logic [3:0]   w_len;
    logic         w_last_byte;
    logic [2:0]   w_cbyte;

    // Length decode looks at the incoming opcode byte so valP can be registered with byte 0.
    y86_instr_len u_len (
        .i_icode       (mem_rdata[7:4]),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_len         (w_len)
    );

    assign w_legal  = ifun_legal(mem_rdata[7:4], mem_rdata[3:0]);
    assign w_accept = (r_state == IDLE) && pc_valid;
    assign w_ack    = (r_state == FETCH) && mem_ack;

    // Constant byte slot: byte index minus the constant's starting offset (1 or 2), mod 8.
    assign w_cbyte  = r_idx[2:0] - 3'd1 - {2'b00, r_need_regids};

    // Fetch ends on a fault, on an illegal/1-byte opcode, or when the final byte is acked.
    assign w_last_byte = mem_err ||
                         ((r_idx == 4'd0) ? (!w_legal || (w_len == 4'd1))
                                          : ((r_idx + 4'd1) == r_len));

    // State register.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_pc_ready   = 1'b0;
        w_mem_req    = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_pc_ready = 1'b1;
                if (pc_valid) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ack && w_last_byte) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch PC on acceptance, then steer each acked byte into its field.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_pc          <= '0;
            r_idx         <= 4'd0;
            r_len         <= 4'd1;
            r_need_regids <= 1'b0;
            r_need_valc   <= 1'b0;
            r_icode       <= 4'd0;
            r_ifun        <= 4'd0;
            r_ra          <= RNONE;
            r_rb          <= RNONE;
            r_valc        <= '0;
            r_valp        <= '0;
            r_instr_valid <= 1'b1;
            r_imem_error  <= 1'b0;
        end else if (w_accept) begin
            r_pc          <= pc_in;
            r_idx         <= 4'd0;
            r_len         <= 4'd1;
            r_need_regids <= 1'b0;
            r_need_valc   <= 1'b0;
            r_icode       <= 4'd0;
            r_ifun        <= 4'd0;
            r_ra          <= RNONE;
            r_rb          <= RNONE;
            r_valc        <= '0;
            r_valp        <= '0;
            r_instr_valid <= 1'b1;
            r_imem_error  <= 1'b0;
        end else if (w_ack) begin
            r_idx <= r_idx + 4'd1;
            if (mem_err) begin
                // Faulting byte is discarded; earlier fields stay as fetched.
                r_imem_error  <= 1'b1;
                r_instr_valid <= 1'b0;
            end else if (r_idx == 4'd0) begin
                r_icode       <= mem_rdata[7:4];
                r_ifun        <= mem_rdata[3:0];
                r_len         <= w_len;
                r_need_regids <= w_need_regids;
                r_need_valc   <= w_need_valc;
                r_valp        <= r_pc + {{(N-4){1'b0}}, w_len};
                if (!w_legal) begin
                    r_instr_valid <= 1'b0;
                end
            end else if (r_need_regids && (r_idx == 4'd1)) begin
                r_ra <= mem_rdata[7:4];
                r_rb <= mem_rdata[3:0];
            end else if (r_need_valc) begin
                r_valc[{w_cbyte, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

    // pc_ready stays low while reset is held even though the state is already IDLE.
    assign pc_ready    = w_pc_ready && async_reset_n;
    assign mem_req     = w_mem_req;
    assign out_valid   = w_out_valid;
    assign mem_addr    = r_pc + {{(N-4){1'b0}}, r_idx};
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign rA          = r_ra;
    assign rB          = r_rb;
    assign valC        = r_valc;
    assign valP        = r_valp;
    assign instr_valid = r_instr_valid;
    assign imem_error  = r_imem_error;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: directed cases plus randomized instructions vs a reference model.
// Latency: checks the out_valid arrival cycle against the byte count and wait states.
// Backpressure: holds out_ready low and toggles pc_valid/out_ready while they must be ignored.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        async_reset_n;
    logic [63:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error, out_valid, out_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [10];

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        iv, ie;
        int          reads;
    } exp_t;

    always #5 clk = ~clk;

    y86_fetch_unit dut (
        .clk(clk), .async_reset_n(async_reset_n),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bytes listed first-to-last, byte 0 in the top 8 bits.
    task automatic load(input logic [79:0] v);
        for (int k = 0; k < 10; k++) mem[k] = v[79-8*k -: 8];
    endtask

    function automatic int ref_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:        return 1;
            4'h2, 4'h6, 4'hA, 4'hB:  return 2;
            4'h7, 4'h8:              return 9;
            4'h3, 4'h4, 4'h5:        return 10;
            default:                 return 1;
        endcase
    endfunction

    // Reference: what the consumer should see for the bytes in mem fetched from pc,
    // with a fault on byte err_at (-1 = no fault).
    function automatic exp_t ref_model(input logic [63:0] pc, input int err_at);
        exp_t e;
        logic [3:0] ic, fn;
        int len, planned, good, s;
        logic legal, has_reg;
        ic = mem[0][7:4];
        fn = mem[0][3:0];
        len = ref_len(ic);
        if (ic > 4'hB)                     legal = 1'b0;
        else if (ic == 4'h2 || ic == 4'h7) legal = (fn <= 4'd6);
        else if (ic == 4'h6)               legal = (fn <= 4'd3);
        else                               legal = (fn == 4'd0);
        planned = legal ? len : 1;
        e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
        e.valc = 64'd0; e.valp = 64'd0; e.iv = 1'b1; e.ie = 1'b0;
        if (err_at >= 0 && err_at < planned) begin
            e.reads = err_at + 1;
            e.ie = 1'b1;
            e.iv = 1'b0;
            good = err_at;
        end else begin
            e.reads = planned;
            good = planned;
        end
        if (good >= 1) begin
            e.icode = ic;
            e.ifun  = fn;
            e.valp  = pc + 64'(len);
            if (!legal) e.iv = 1'b0;
        end
        has_reg = (len == 2) || (len == 10);
        s = has_reg ? 2 : 1;
        if (has_reg && good >= 2) begin
            e.ra = mem[1][7:4];
            e.rb = mem[1][3:0];
        end
        if (len >= 9) begin
            for (int k = s; k < good; k++) e.valc = e.valc | (64'(mem[k]) << (8 * (k - s)));
        end
        return e;
    endfunction

    // One full fetch: issue pc, serve memory with 'waits' stall cycles per byte,
    // then hold the result 'hold' cycles before consuming it.
    task automatic run(input string nm, input logic [63:0] pc, input int err_at,
                       input int waits, input int hold);
        exp_t e;
        int cyc, nreads, wc;
        e = ref_model(pc, err_at);
        chk({nm, ".pc_ready0"}, 64'(pc_ready), 64'd1);
        pc_in = pc;
        pc_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1; nreads = 0; wc = 0;
        pc_valid = 1'b0;
        while (!out_valid && cyc < 400) begin
            if (mem_req) begin
                chk({nm, ".addr"}, mem_addr, pc + 64'(nreads));
                if (wc < waits) begin
                    mem_ack = 1'b0;
                    wc++;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = (nreads < 10) ? mem[nreads] : 8'h00;
                    mem_err   = (nreads == err_at);
                    nreads++;
                    wc = 0;
                end
            end
            @(posedge clk);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = 8'($urandom);
            // Both must be ignored while fetching.
            out_ready = 1'($urandom);
            pc_valid  = 1'($urandom);
            pc_in     = {$urandom, $urandom};
            cyc++;
        end
        out_ready = 1'b0;
        pc_valid  = 1'b0;
        chk({nm, ".latency"}, 64'(cyc), 64'(1 + e.reads * (1 + waits)));
        chk({nm, ".reads"}, 64'(nreads), 64'(e.reads));
        for (int h = 0; h <= hold; h++) begin
            chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
            chk({nm, ".pc_ready"}, 64'(pc_ready), 64'd0);
            chk({nm, ".mem_req"}, 64'(mem_req), 64'd0);
            chk({nm, ".icode"}, 64'(icode), 64'(e.icode));
            chk({nm, ".ifun"}, 64'(ifun), 64'(e.ifun));
            chk({nm, ".rA"}, 64'(rA), 64'(e.ra));
            chk({nm, ".rB"}, 64'(rB), 64'(e.rb));
            chk({nm, ".valC"}, valC, e.valc);
            chk({nm, ".valP"}, valP, e.valp);
            chk({nm, ".instr_valid"}, 64'(instr_valid), 64'(e.iv));
            chk({nm, ".imem_error"}, 64'(imem_error), 64'(e.ie));
            if (h < hold) begin
                pc_valid = 1'b1;
                pc_in = {$urandom, $urandom};
                @(posedge clk);
                @(negedge clk);
                pc_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, ".consumed"}, 64'(out_valid), 64'd0);
        chk({nm, ".pc_ready1"}, 64'(pc_ready), 64'd1);
    endtask

    // Start an irmovq, then pull reset while byte 5 is being requested.
    task automatic reset_mid_fetch();
        logic [63:0] pc;
        pc = 64'h3000;
        load(80'h30F3EFCDAB8967452301);
        pc_in = pc;
        pc_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            mem_ack = 1'b1;
            mem_rdata = mem[b];
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("rst.req_before", 64'(mem_req), 64'd1);
        chk("rst.addr5", mem_addr, pc + 64'd5);
        #2;
        async_reset_n = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = mem[5];
        #1;
        chk("rst.req_async", 64'(mem_req), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.pc_ready", 64'(pc_ready), 64'd0);
        chk("rst.icode", 64'(icode), 64'd0);
        chk("rst.valC", valC, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst.req_held", 64'(mem_req), 64'd0);
        async_reset_n = 1'b1;
        mem_ack = 1'b0;
        #1;
        chk("rst.pc_ready_after", 64'(pc_ready), 64'd1);
        chk("rst.rA", 64'(rA), 64'hF);
        chk("rst.instr_valid", 64'(instr_valid), 64'd1);
    endtask

    initial begin
        logic [3:0] ic, fn;
        int err_at;
        async_reset_n = 1'b0;
        pc_in = 64'd0; pc_valid = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'd0; mem_err = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset.pc_ready", 64'(pc_ready), 64'd0);
        chk("reset.mem_req", 64'(mem_req), 64'd0);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        chk("reset.icode", 64'(icode), 64'd0);
        chk("reset.rA", 64'(rA), 64'hF);
        chk("reset.rB", 64'(rB), 64'hF);
        chk("reset.valC", valC, 64'd0);
        chk("reset.valP", valP, 64'd0);
        chk("reset.instr_valid", 64'(instr_valid), 64'd1);
        chk("reset.imem_error", 64'(imem_error), 64'd0);
        async_reset_n = 1'b1;
        #1;
        chk("reset.pc_ready_idle", 64'(pc_ready), 64'd1);
        @(negedge clk);

        load(80'h30F3EFCDAB8967452301);  run("irmovq", 64'h100, -1, 0, 0);
        load({8'h00, 72'h0});             run("halt", 64'h200, -1, 0, 0);
        load(80'h80000100000000000000);  run("call_wait", 64'h40, -1, 1, 0);
        load({8'hD0, 72'h0});             run("bad_icode", 64'h0, -1, 0, 0);
        load({8'h64, 72'h0});             run("bad_ifun", 64'h0, -1, 0, 0);
        load({8'h60, 8'h12, 64'h0});      run("wrap", 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 5);
        load(80'h5012_1122334455667788);  run("mrmov_err", 64'h800, 3, 0, 1);
        reset_mid_fetch();
        load(80'h30F3EFCDAB8967452301);  run("after_reset", 64'h3000, -1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
            else if (ic == 4'h6)          fn = 4'($urandom_range(0, 3));
            else                          fn = 4'h0;
            load({$urandom, $urandom, 16'($urandom)});
            mem[0] = {ic, fn};
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run($sformatf("rand%0d", i), {$urandom, $urandom}, err_at,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
